// File: rtl/decode_bypass_controller.sv
// Decode-stage operand bypass selection and load-use stall control.
// Define DECODE_BYPASS_WB_EN to enable forwarding from the WB stage.
module decode_bypass_controller #(
    parameter int REG_ADDR_WIDTH  = 5,
    parameter int STALL_CNT_WIDTH = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       decode_valid,
    input  logic [REG_ADDR_WIDTH-1:0]  decode_rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0]  decode_rs2_addr,
    input  logic                       decode_rs1_used,
    input  logic                       decode_rs2_used,
    input  logic [REG_ADDR_WIDTH-1:0]  decode_rd_addr,
    input  logic                       decode_regwrite,
    input  logic                       decode_is_load,
    input  logic                       pipe_hold,
    input  logic                       flush,
    output logic [1:0]                 rs1_data_bypass,
    output logic [1:0]                 rs2_data_bypass,
    output logic                       stall_decode,
    output logic                       bubble_active,
    output logic [STALL_CNT_WIDTH-1:0] stall_count
);

    typedef struct packed {
        logic                      valid;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic                      regwrite;
        logic                      is_load;
    } entry_t;

    typedef enum logic {
        IDLE,
        LOAD_STALL
    } state_t;

    entry_t ex_q;
    entry_t mem_q;
    entry_t wb_q;
    entry_t dec_entry;
    state_t state_q;
    logic [STALL_CNT_WIDTH-1:0] cnt_q;

    logic rs1_ex, rs1_mem, rs1_wb;
    logic rs2_ex, rs2_mem, rs2_wb;
    logic load_use;
    logic advance;
    logic unused_bits;

    function automatic logic hit(
        input entry_t                    e,
        input logic                      dv,
        input logic                      used,
        input logic [REG_ADDR_WIDTH-1:0] rs
    );
        return dv && used && (rs != '0) && e.valid && e.regwrite && (e.rd == rs);
    endfunction

    assign rs1_ex  = hit(ex_q, decode_valid, decode_rs1_used, decode_rs1_addr);
    assign rs2_ex  = hit(ex_q, decode_valid, decode_rs2_used, decode_rs2_addr);
    assign rs1_mem = hit(mem_q, decode_valid, decode_rs1_used, decode_rs1_addr);
    assign rs2_mem = hit(mem_q, decode_valid, decode_rs2_used, decode_rs2_addr);

`ifdef DECODE_BYPASS_WB_EN
    assign rs1_wb = hit(wb_q, decode_valid, decode_rs1_used, decode_rs1_addr);
    assign rs2_wb = hit(wb_q, decode_valid, decode_rs2_used, decode_rs2_addr);
`else
    // Write-first register file already returns the WB result.
    assign rs1_wb = 1'b0;
    assign rs2_wb = 1'b0;
`endif

    always_comb begin
        rs1_data_bypass = 2'b00;
        if (rs1_ex)       rs1_data_bypass = 2'b01;
        else if (rs1_mem) rs1_data_bypass = 2'b10;
        else if (rs1_wb)  rs1_data_bypass = 2'b11;
    end

    always_comb begin
        rs2_data_bypass = 2'b00;
        if (rs2_ex)       rs2_data_bypass = 2'b01;
        else if (rs2_mem) rs2_data_bypass = 2'b10;
        else if (rs2_wb)  rs2_data_bypass = 2'b11;
    end

    assign load_use     = ex_q.is_load && (rs1_ex || rs2_ex);
    assign stall_decode = load_use && !flush;
    assign advance      = decode_valid && !stall_decode;

    always_comb begin
        dec_entry          = '0;
        dec_entry.valid    = 1'b1;
        dec_entry.rd       = decode_rd_addr;
        dec_entry.regwrite = decode_regwrite;
        dec_entry.is_load  = decode_is_load;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
        end else if (flush) begin
            // A redirect kills EX/MEM even while the pipe is frozen.
            ex_q.valid  <= 1'b0;
            mem_q.valid <= 1'b0;
            state_q     <= IDLE;
            if (!pipe_hold) begin
                wb_q <= mem_q;
            end
        end else if (!pipe_hold) begin
            ex_q    <= advance ? dec_entry : '0;
            mem_q   <= ex_q;
            wb_q    <= mem_q;
            state_q <= stall_decode ? LOAD_STALL : IDLE;
            if (stall_decode && (cnt_q != '1)) begin
                cnt_q <= cnt_q + {{(STALL_CNT_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

    assign bubble_active = (state_q == LOAD_STALL);
    assign stall_count   = cnt_q;

    assign unused_bits = ^{wb_q, mem_q.is_load};

endmodule

// File: tb/tb_decode_bypass_controller.sv
// Scoreboard bench for decode_bypass_controller: directed vectors,
// expected responses queued by stimulus and checked by a monitor.
module tb_decode_bypass_controller;

    logic       clk;
    logic       reset;
    logic       decode_valid;
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, rw, ld;
    logic       pipe_hold;
    logic       flush;

    logic [1:0]  rs1_sel, rs2_sel;
    logic        stall;
    logic        bubble;
    logic [15:0] cnt;

    logic [1:0] s_rs1_sel, s_rs2_sel;
    logic       s_stall, s_bubble;
    logic [1:0] s_cnt;

`ifdef DECODE_BYPASS_WB_EN
    localparam logic [1:0] WB = 2'b11;
`else
    localparam logic [1:0] WB = 2'b00;
`endif

    typedef struct {
        string       name;
        logic [1:0]  s1;
        logic [1:0]  s2;
        logic        st;
        logic        bub;
        logic [15:0] cnt;
        logic [1:0]  cs;
    } exp_t;

    exp_t sbq[$];
    int   n_vec;
    int   n_bad;

    decode_bypass_controller dut (
        .clock           (clk),
        .reset           (reset),
        .decode_valid    (decode_valid),
        .decode_rs1_addr (rs1),
        .decode_rs2_addr (rs2),
        .decode_rs1_used (u1),
        .decode_rs2_used (u2),
        .decode_rd_addr  (rd),
        .decode_regwrite (rw),
        .decode_is_load  (ld),
        .pipe_hold       (pipe_hold),
        .flush           (flush),
        .rs1_data_bypass (rs1_sel),
        .rs2_data_bypass (rs2_sel),
        .stall_decode    (stall),
        .bubble_active   (bubble),
        .stall_count     (cnt)
    );

    // Narrow counter copy exercises saturation at all-ones.
    decode_bypass_controller #(.STALL_CNT_WIDTH(2)) dut_sat (
        .clock           (clk),
        .reset           (reset),
        .decode_valid    (decode_valid),
        .decode_rs1_addr (rs1),
        .decode_rs2_addr (rs2),
        .decode_rs1_used (u1),
        .decode_rs2_used (u2),
        .decode_rd_addr  (rd),
        .decode_regwrite (rw),
        .decode_is_load  (ld),
        .pipe_hold       (pipe_hold),
        .flush           (flush),
        .rs1_data_bypass (s_rs1_sel),
        .rs2_data_bypass (s_rs2_sel),
        .stall_decode    (s_stall),
        .bubble_active   (s_bubble),
        .stall_count     (s_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(
        input logic       v,
        input logic [4:0] r1, input logic a1,
        input logic [4:0] r2, input logic a2,
        input logic [4:0] d,  input logic w, input logic l,
        input logic       h,  input logic f
    );
        @(negedge clk);
        decode_valid = v;
        rs1 = r1; u1 = a1;
        rs2 = r2; u2 = a2;
        rd = d; rw = w; ld = l;
        pipe_hold = h;
        flush = f;
    endtask

    task automatic push_exp(
        input string      n,
        input logic [1:0] s1, input logic [1:0] s2,
        input logic       st, input logic bub,
        input int         c
    );
        exp_t e;
        e.name = n;
        e.s1 = s1;
        e.s2 = s2;
        e.st = st;
        e.bub = bub;
        e.cnt = 16'(c);
        e.cs = (c > 3) ? 2'd3 : 2'(c);
        sbq.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                n_vec++;
                if ({rs1_sel, rs2_sel, stall, bubble, cnt, s_cnt} !==
                    {e.s1, e.s2, e.st, e.bub, e.cnt, e.cs}) begin
                    n_bad++;
                    $display("FAIL %s: got s1=%b s2=%b st=%b bub=%b cnt=%0d sat=%0d, want s1=%b s2=%b st=%b bub=%b cnt=%0d sat=%0d",
                             e.name, rs1_sel, rs2_sel, stall, bubble, cnt, s_cnt,
                             e.s1, e.s2, e.st, e.bub, e.cnt, e.cs);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        n_vec = 0;
        n_bad = 0;
        reset = 1'b0;
        decode_valid = 0; rs1 = 0; rs2 = 0; rd = 0;
        u1 = 0; u2 = 0; rw = 0; ld = 0; pipe_hold = 0; flush = 0;

        drive(0, 0,0, 0,0, 0,0,0, 0,0); push_exp("reset", 0, 0, 0, 0, 0);
        #4 reset = 1'b1;

        drive(1, 0,0, 0,0, 5,1,0, 0,0); push_exp("add_x5", 0, 0, 0, 0, 0);
        drive(1, 5,1, 6,1, 6,1,0, 0,0); push_exp("fwd_ex", 1, 0, 0, 0, 0);
        drive(1, 5,1, 6,1, 0,0,0, 0,0); push_exp("fwd_mem", 2, 1, 0, 0, 0);
        drive(1, 5,1, 6,1, 0,0,0, 0,0); push_exp("fwd_wb", WB, 2, 0, 0, 0);

        drive(1, 0,0, 0,0, 7,1,1, 0,0); push_exp("lw_x7", 0, 0, 0, 0, 0);
        drive(1, 0,0, 7,1, 8,1,0, 0,0); push_exp("load_use", 0, 1, 1, 0, 0);
        drive(1, 0,0, 7,1, 8,1,0, 0,0); push_exp("bubble", 0, 2, 0, 1, 1);
        drive(0, 0,0, 0,0, 0,0,0, 0,0); push_exp("after_stall", 0, 0, 0, 0, 1);

        repeat (3) begin
            drive(1, 0,0, 0,0, 3,1,0, 0,0); push_exp("x3_issue", 0, 0, 0, 0, 1);
        end
        drive(1, 3,1, 0,0, 0,0,0, 1,0); push_exp("x3_ex_first", 1, 0, 0, 0, 1);
        drive(0, 3,1, 0,0, 0,0,0, 0,0); push_exp("x3_gap", 0, 0, 0, 0, 1);
        drive(0, 3,1, 0,0, 0,0,0, 0,0); push_exp("x3_gap", 0, 0, 0, 0, 1);
        drive(1, 3,1, 0,0, 0,0,0, 0,0); push_exp("x3_wb", WB, 0, 0, 0, 1);

        drive(1, 0,0, 0,0, 0,1,0, 0,0); push_exp("wr_x0", 0, 0, 0, 0, 1);
        drive(1, 0,1, 0,1, 0,0,0, 0,0); push_exp("rd_x0", 0, 0, 0, 0, 1);

        drive(1, 0,0, 0,0, 9,1,1, 0,0); push_exp("lw_x9", 0, 0, 0, 0, 1);
        drive(1, 9,1, 9,0, 0,0,0, 0,1); push_exp("flush_lu", 1, 0, 0, 0, 1);
        drive(1, 9,1, 0,0, 0,0,0, 0,0); push_exp("post_flush", 0, 0, 0, 0, 1);

        drive(1, 0,0, 0,0, 4,1,1, 0,0); push_exp("lw_x4", 0, 0, 0, 0, 1);
        drive(1, 4,1, 0,0, 0,0,0, 1,1); push_exp("flush_hold", 1, 0, 0, 0, 1);
        drive(1, 4,1, 0,0, 0,0,0, 0,0); push_exp("post_flush_hold", 0, 0, 0, 0, 1);

        drive(1, 0,0, 0,0, 7,1,1, 0,0); push_exp("lw_x7b", 0, 0, 0, 0, 1);
        drive(1, 7,1, 0,0, 0,0,0, 1,0); push_exp("lu_held", 1, 0, 1, 0, 1);
        drive(1, 7,1, 0,0, 0,0,0, 0,0); push_exp("lu_take", 1, 0, 1, 0, 1);
        drive(1, 7,1, 0,0, 0,0,0, 1,0); push_exp("bubble_held", 2, 0, 0, 1, 2);
        drive(1, 7,1, 0,0, 0,0,0, 0,0); push_exp("bubble_rel", 2, 0, 0, 1, 2);
        drive(0, 0,0, 0,0, 0,0,0, 0,0); push_exp("idle", 0, 0, 0, 0, 2);

        for (int k = 2; k <= 4; k++) begin
            drive(1, 0,0, 0,0, 7,1,1, 0,0); push_exp("sat_lw", 0, 0, 0, 0, k);
            drive(1, 0,0, 7,1, 0,0,0, 0,0); push_exp("sat_lu", 0, 1, 1, 0, k);
            drive(1, 0,0, 7,1, 0,0,0, 0,0); push_exp("sat_bub", 0, 2, 0, 1, k + 1);
        end

        drive(1, 0,0, 0,0, 7,1,1, 0,0); push_exp("rst_lw", 0, 0, 0, 0, 5);
        drive(1, 0,0, 7,1, 0,0,0, 0,0); push_exp("rst_lu", 0, 1, 1, 0, 5);
        drive(1, 0,0, 7,1, 0,0,0, 0,0);
        reset = 1'b0;
        push_exp("rst_mid", 0, 0, 0, 0, 0);
        drive(1, 0,0, 7,1, 0,0,0, 0,0);
        reset = 1'b1;
        push_exp("rst_after", 0, 0, 0, 0, 0);

        repeat (4) @(negedge clk);
        if (sbq.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d vectors left unchecked, want 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
